// File: rtl/ififo.sv
// ----------------------------------------------------------------------------
// ififo : instruction FIFO between fetch and decode
//
// Buffers instruction words pushed by fetch and presents the oldest word
// show-ahead to the decoder. Flushes on a taken jump so that no stale words
// that follow the jump reach decode.
//
// Parameters
//   WIDTH        word width ({5-bit op, 3-bit field, 16-bit payload})
//   DEPTH        number of entries (power of two, >= 2)
//   AFULL_LEVEL  ififo_almost_full asserts when count >= this value
//
// Ports
//   clk                in   single clock, rising edge
//   reset              in   synchronous, active-high reset
//   ififo_shift        in   push request from fetch
//   ififo_di           in   word to push
//   ififo_flush        in   discard all contents (jump enable)
//   ififo_pop          in   decoder consumed the head word
//   ififo_do           out  head word, valid when ififo_valid = 1
//   ififo_valid        out  FIFO non-empty
//   ififo_full         out  count == DEPTH
//   ififo_almost_full  out  count >= AFULL_LEVEL (fetch stalls on this)
//   ififo_count        out  number of stored words
//   ififo_overflow     out  sticky: a push was dropped while full
// ----------------------------------------------------------------------------
module ififo #(
  parameter int WIDTH       = 24,
  parameter int DEPTH       = 8,
  parameter int AFULL_LEVEL = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ififo_shift,
  input  logic [WIDTH-1:0]           ififo_di,
  input  logic                       ififo_flush,
  input  logic                       ififo_pop,
  output logic [WIDTH-1:0]           ififo_do,
  output logic                       ififo_valid,
  output logic                       ififo_full,
  output logic                       ififo_almost_full,
  output logic [$clog2(DEPTH):0]     ififo_count,
  output logic                       ififo_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [CW-1:0]    r_count;
  logic             r_overflow;

  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [CW-1:0]    w_count_nxt;

  // Flags are decoded from the registered count only.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));

  // A pop on an empty FIFO is ignored (no fall-through). A push into a full
  // FIFO is accepted only when a pop frees the head slot in the same cycle;
  // then wp == rp, and the head is read out before the edge overwrites it.
  assign w_pop   = ififo_pop && !w_empty;
  assign w_push  = ififo_shift && (!w_full || w_pop);
  assign w_drop  = ififo_shift && w_full && !w_pop;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  // ---- storage write (data, not reset) ----
  always_ff @(posedge clk) begin
    if (!reset && !ififo_flush && w_push) begin
      r_mem[r_wp] <= ififo_di;
    end
  end

  // ---- control state: pointers, count, sticky overflow ----
  // Reset outranks flush, flush outranks push/pop. A push discarded by a
  // flush is not an overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (ififo_flush) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_wp <= r_wp + AW'(1);
      end
      if (w_pop) begin
        r_rp <= r_rp + AW'(1);
      end
      r_count <= w_count_nxt;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // ---- outputs, all from registered state ----
  // Storage is not cleared by reset, so the head is forced to zero while
  // empty; this gives ififo_do = 0 after reset.
  assign ififo_do          = w_empty ? '0 : r_mem[r_rp];
  assign ififo_valid       = !w_empty;
  assign ififo_full        = w_full;
  assign ififo_almost_full = (r_count >= CW'(AFULL_LEVEL));
  assign ififo_count       = r_count;
  assign ififo_overflow    = r_overflow;

endmodule
